// File: rtl/botones_pkg.sv
// Shared constants for the pushbutton conditioner: default timings, button
// indices into the 4-bit vectors and the auto-repeat state encoding.
package botones_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int REPEAT_DELAY_DEF    = 25000000;
  localparam int REPEAT_PERIOD_DEF   = 5000000;

  localparam int UP   = 0;
  localparam int DOWN = 1;
  localparam int TC   = 2;
  localparam int LP   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  // The repeat counter only ever has to reach the larger of the two intervals minus one.
  function automatic int rep_cnt_width(input int delay, input int period);
    return $clog2((delay > period) ? delay : period);
  endfunction

endpackage

// File: rtl/acondicionador_botones_antirrebote.sv
// One button channel: two-flop synchroniser, stable-count debounce and a
// rising-edge strobe of the debounced level (the caller registers the strobe).
module antirrebote
  import botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic Clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic          level_next;
  logic          level_d_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // The counter only runs while the synced input disagrees with the accepted
  // level, so any agreeing cycle restarts the stability window.
  always_comb begin
    level_next = level_reg;
    cnt_next   = '0;
    if (sync_reg[1] != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        level_next = ~level_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      sync_reg    <= '0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync_reg    <= {sync_reg[0], raw};
      level_reg   <= level_next;
      level_d_reg <= level_reg;
      cnt_reg     <= cnt_next;
    end
  end

  assign level = level_reg;
  assign rise  = level_reg & ~level_d_reg;

endmodule

// File: rtl/acondicionador_botones.sv
// Pushbutton conditioner feeding the chroma control: four debounced channels,
// auto-repeat on Up/Down, Up/Down mutual exclusion, all outputs registered.
module acondicionador_botones #(
  parameter int DEBOUNCE_CYCLES = botones_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = botones_pkg::REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = botones_pkg::REPEAT_PERIOD_DEF
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Up_in,
  input  logic       Down_in,
  input  logic       TC_in,
  input  logic       Lp_in,
  output logic       Up,
  output logic       Down,
  output logic       TC,
  output logic       Lp,
  output logic [3:0] held
);

  import botones_pkg::*;

  localparam int RW = rep_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [3:0] raw_vec;
  logic [3:0] level_vec;
  logic [3:0] rise_vec;
  logic [1:0] rep_fire;
  logic       conflict;
  logic [3:0] out_reg;
  logic [3:0] out_next;

  assign raw_vec  = {Lp_in, TC_in, Down_in, Up_in};
  assign conflict = level_vec[botones_pkg::UP] & level_vec[botones_pkg::DOWN];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      antirrebote #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_antirrebote (
        .Clk  (Clk),
        .reset(reset),
        .raw  (raw_vec[gi]),
        .level(level_vec[gi]),
        .rise (rise_vec[gi])
      );
    end

    // Up (0) and Down (1) each get a repeat FSM; a conflict parks both in IDLE
    // and only a fresh press can leave IDLE, so the survivor stays silent.
    for (gi = 0; gi < 2; gi++) begin : g_rep
      rep_state_e    state_reg;
      rep_state_e    state_next;
      logic [RW-1:0] cnt_reg;
      logic [RW-1:0] cnt_next;
      logic          fire;

      always_ff @(posedge Clk) begin
        if (reset) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        if (!level_vec[gi] || conflict) begin
          state_next = IDLE;
        end else begin
          case (state_reg)
            IDLE: begin
              if (rise_vec[gi]) state_next = WAIT;
            end
            WAIT: begin
              if (cnt_reg == DLY_LAST) state_next = REPEAT;
              else cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
            end
            REPEAT: begin
              if (cnt_reg != PER_LAST) cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
            end
            default: state_next = IDLE;
          endcase
        end
      end

      always_comb begin
        fire = 1'b0;
        if (level_vec[gi] && !conflict) begin
          case (state_reg)
            WAIT:    fire = (cnt_reg == DLY_LAST);
            REPEAT:  fire = (cnt_reg == PER_LAST);
            default: fire = 1'b0;
          endcase
        end
      end

      assign rep_fire[gi] = fire;
    end
  endgenerate

  always_comb begin
    out_next = '0;
    out_next[botones_pkg::UP]   = (rise_vec[botones_pkg::UP] & ~conflict) | rep_fire[0];
    out_next[botones_pkg::DOWN] = (rise_vec[botones_pkg::DOWN] & ~conflict) | rep_fire[1];
    out_next[botones_pkg::TC]   = rise_vec[botones_pkg::TC];
    out_next[botones_pkg::LP]   = rise_vec[botones_pkg::LP];
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      out_reg <= '0;
    end else begin
      out_reg <= out_next;
    end
  end

  assign Up   = out_reg[botones_pkg::UP];
  assign Down = out_reg[botones_pkg::DOWN];
  assign TC   = out_reg[botones_pkg::TC];
  assign Lp   = out_reg[botones_pkg::LP];
  assign held = level_vec;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones: directed scenarios with fixed expected pulse
// edges, then random button activity checked every cycle against a reference model.
module tb_acondicionador_botones;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       Up_in = 1'b0, Down_in = 1'b0, TC_in = 1'b0, Lp_in = 1'b0;
  logic       Up, Down, TC, Lp;
  logic [3:0] held;

  acondicionador_botones #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .Clk    (Clk),
    .reset  (reset),
    .Up_in  (Up_in),
    .Down_in(Down_in),
    .TC_in  (TC_in),
    .Lp_in  (Lp_in),
    .Up     (Up),
    .Down   (Down),
    .TC     (TC),
    .Lp     (Lp),
    .held   (held)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: raw history, accepted levels, mismatch run lengths,
  // and for Up/Down the edge of the press that started the current hold.
  bit [3:0]   hist[$];
  bit [3:0]   m_held = '0;
  bit [3:0]   m_held_prev = '0;
  int         m_run[4];
  bit         m_valid[2];
  int         m_start[2];
  int         m_edge = 0;
  logic [3:0] exp_pulse = '0;
  logic [3:0] exp_held = '0;

  int sc_edge = 0;
  int q_up[$], q_dn[$], q_tc[$], q_lp[$];
  int tc_rise = -1, tc_fall = -1;
  bit lp_held_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_list(input string tag, input int got[$], input int want[$]);
    chk({tag, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++) begin
      if (i < got.size()) chk({tag, "_edge"}, got[i], want[i]);
    end
  endtask

  task automatic model_edge(input logic [3:0] raw, input logic rst);
    bit [3:0] syn, hb, rise;
    bit both;
    int k;
    if (rst) begin
      hist.delete();
      m_held = '0;
      m_held_prev = '0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      for (int b = 0; b < 2; b++) m_valid[b] = 1'b0;
      m_edge = 0;
      exp_pulse = '0;
      exp_held = '0;
      return;
    end
    m_edge++;
    hist.push_back(raw);
    if (hist.size() > 3) void'(hist.pop_front());
    syn  = (hist.size() == 3) ? hist[0] : 4'b0000;
    hb   = m_held;
    rise = hb & ~m_held_prev;
    both = hb[0] & hb[1];
    exp_pulse = '0;
    exp_pulse[2] = rise[2];
    exp_pulse[3] = rise[3];
    for (int b = 0; b < 2; b++) begin
      if (!hb[b] || both) begin
        m_valid[b] = 1'b0;
      end else if (rise[b]) begin
        m_valid[b] = 1'b1;
        m_start[b] = m_edge;
        exp_pulse[b] = 1'b1;
      end else if (m_valid[b]) begin
        k = m_edge - m_start[b];
        exp_pulse[b] = (k == RD) || (k > RD && ((k - RD) % RP) == 0);
      end
    end
    for (int b = 0; b < 4; b++) begin
      if (syn[b] != hb[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_held[b] = ~m_held[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_held_prev = hb;
    exp_held = m_held;
  endtask

  // raw is {Lp,TC,Down,Up}; it is presented before the next rising edge.
  task automatic step(input logic [3:0] raw, input logic rst);
    {Lp_in, TC_in, Down_in, Up_in} = raw;
    reset = rst;
    @(posedge Clk);
    model_edge(raw, rst);
    sc_edge++;
    @(negedge Clk);
    chk("held", held, exp_held);
    chk("pulses", {Lp, TC, Down, Up}, exp_pulse);
    if (Up)   q_up.push_back(sc_edge);
    if (Down) q_dn.push_back(sc_edge);
    if (TC)   q_tc.push_back(sc_edge);
    if (Lp)   q_lp.push_back(sc_edge);
    if (held[2] && tc_rise < 0) tc_rise = sc_edge;
    if (!held[2] && tc_rise >= 0 && tc_fall < 0) tc_fall = sc_edge;
    if (held[3]) lp_held_seen = 1'b1;
  endtask

  task automatic begin_scn();
    step(4'b0000, 1'b1);
    sc_edge = 0;
    q_up.delete(); q_dn.delete(); q_tc.delete(); q_lp.delete();
    tc_rise = -1; tc_fall = -1;
    lp_held_seen = 1'b0;
  endtask

  int e[$];
  int none[$];
  logic [3:0] cur;
  int remain[4];

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    chk("reset_held", held, 4'b0000);
    chk("reset_pulses", {Lp, TC, Down, Up}, 4'b0000);

    // Clean TC press held for 40 cycles
    begin_scn();
    for (int i = 1; i <= 40; i++) step(4'b0100, 1'b0);
    for (int i = 0; i < 20; i++) step(4'b0000, 1'b0);
    e = '{7};
    chk_list("tc_press", q_tc, e);
    chk("tc_held_rise", tc_rise, 6);
    chk("tc_held_fall", tc_fall, 46);
    chk_list("tc_no_up", q_up, none);

    // Bouncing Lp settling high
    begin_scn();
    step(4'b1000, 1'b0); step(4'b0000, 1'b0); step(4'b1000, 1'b0); step(4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) step(4'b1000, 1'b0);
    for (int i = 0; i < 15; i++) step(4'b0000, 1'b0);
    e = '{11};
    chk_list("lp_bounce", q_lp, e);

    // 3-cycle glitches only
    begin_scn();
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 3; i++) step(4'b1000, 1'b0);
      for (int i = 0; i < 5; i++) step(4'b0000, 1'b0);
    end
    chk_list("lp_glitch", q_lp, none);
    chk("lp_glitch_held", lp_held_seen, 1'b0);

    // Up held 60 cycles: press plus repeats
    begin_scn();
    for (int i = 1; i <= 60; i++) step(4'b0001, 1'b0);
    for (int i = 0; i < 30; i++) step(4'b0000, 1'b0);
    e = '{7, 27, 35, 43, 51, 59};
    chk_list("up_repeat", q_up, e);

    // Up/Down conflict
    begin_scn();
    for (int i = 1; i <= 80; i++) step({2'b00, (i >= 11), (i <= 50)}, 1'b0);
    for (int i = 0; i < 30; i++) step(4'b0000, 1'b0);
    e = '{7};
    chk_list("conflict_up", q_up, e);
    chk_list("conflict_down", q_dn, none);

    // Reset while Down is repeating
    begin_scn();
    for (int i = 1; i <= 64; i++) begin
      step(4'b0010, (i == 30 || i == 31));
      if (i == 30 || i == 31) chk("reset_mid_outputs", {held, Lp, TC, Down, Up}, 8'h00);
    end
    for (int i = 0; i < 20; i++) step(4'b0000, 1'b0);
    e = '{7, 27, 38, 58, 66};
    chk_list("reset_mid_down", q_dn, e);

    // Simultaneous TC and Lp
    begin_scn();
    for (int i = 0; i < 15; i++) step(4'b1100, 1'b0);
    for (int i = 0; i < 15; i++) step(4'b0000, 1'b0);
    e = '{7};
    chk_list("sim_tc", q_tc, e);
    chk_list("sim_lp", q_lp, e);

    // Random activity, checked cycle by cycle against the model
    begin_scn();
    cur = '0;
    for (int b = 0; b < 4; b++) remain[b] = $urandom_range(1, 40);
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (remain[b] == 0) begin
          cur[b] = ~cur[b];
          remain[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 70);
        end
        remain[b]--;
      end
      step(cur, ($urandom_range(0, 599) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
